// File: rtl/wta_pipe_tree.sv
// Pipelined Wallace-tree adder: NUM_PP unsigned operands reduced by 3:2 CSA layers,
// registered every REG_EVERY layers, then a registered carry-propagate add.
module wta_pipe_tree #(
  parameter int NUM_PP = 10,
  parameter int PP_WIDTH = 32,
  parameter int REG_EVERY = 2,
  localparam int OUT_WIDTH = PP_WIDTH + $clog2(NUM_PP)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_PP*PP_WIDTH-1:0] pp_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_sum
);

  function automatic int num_layers(input int np);
    int n;
    int l;
    n = np;
    l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  // operand count entering layer k
  function automatic int layer_n(input int k);
    int n;
    n = NUM_PP;
    for (int i = 0; i < k; i++)
      n = n - n / 3;
    return n;
  endfunction

  localparam int L = num_layers(NUM_PP);
  localparam int S = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int LD = (L > 0) ? L : 1;
  localparam int SD = (S > 0) ? S : 1;

  // last CSA layer folded into stage s
  function automatic int stage_last(input int s);
    int e;
    e = (s + 1) * REG_EVERY;
    if (e > L)
      e = L;
    return e - 1;
  endfunction

  typedef logic [OUT_WIDTH-1:0] word_t;

  word_t         ext   [NUM_PP];
  word_t         cur   [LD][NUM_PP];
  word_t         nxt   [LD][NUM_PP];
  word_t         stg_q [SD][NUM_PP];
  logic [SD-1:0] stg_v;
  word_t         cpa_a;
  word_t         cpa_b;
  logic          last_v;
  logic          stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // zero-extend every operand to the result width
  always_comb begin
    for (int j = 0; j < NUM_PP; j++)
      ext[j] = {{(OUT_WIDTH-PP_WIDTH){1'b0}},
                pp_in[j*PP_WIDTH +: PP_WIDTH]};
  end

  // CSA layers; a stage boundary takes its operands from the stage register
  always_comb begin
    int n;
    int g3;
    int si;
    int di;
    n  = 0;
    g3 = 0;
    si = 0;
    di = 0;
    for (int k = 0; k < LD; k++)
      for (int j = 0; j < NUM_PP; j++) begin
        cur[k][j] = '0;
        nxt[k][j] = '0;
      end
    for (int k = 0; k < L; k++) begin
      n  = layer_n(k);
      g3 = n / 3;
      for (int j = 0; j < NUM_PP; j++) begin
        if (k == 0)
          cur[k][j] = ext[j];
        else if (k % REG_EVERY == 0)
          cur[k][j] = stg_q[k / REG_EVERY - 1][j];
        else
          cur[k][j] = nxt[k - 1][j];
      end
      for (int g = 0; g < NUM_PP / 3; g++) begin
        if (g < g3) begin
          nxt[k][2*g] = cur[k][3*g] ^ cur[k][3*g+1]
                      ^ cur[k][3*g+2];
          nxt[k][2*g+1] = ((cur[k][3*g] & cur[k][3*g+1])
                        | (cur[k][3*g] & cur[k][3*g+2])
                        | (cur[k][3*g+1] & cur[k][3*g+2])) << 1;
        end
      end
      for (int t = 0; t < 2; t++) begin
        si = 3 * g3 + t;
        di = 2 * g3 + t;
        if (si < n)
          nxt[k][di] = cur[k][si];
      end
    end
  end

  if (S > 0) begin : g_stg
    // CSA stage registers with their valid bits; all hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_v <= '0;
        for (int s = 0; s < SD; s++)
          for (int j = 0; j < NUM_PP; j++)
            stg_q[s][j] <= '0;
      end else if (!stall) begin
        stg_v[0] <= in_valid;
        for (int s = 1; s < S; s++)
          stg_v[s] <= stg_v[s-1];
        for (int s = 0; s < S; s++)
          for (int j = 0; j < NUM_PP; j++)
            stg_q[s][j] <= nxt[stage_last(s)][j];
      end
    end

    assign cpa_a  = stg_q[S-1][0];
    assign cpa_b  = stg_q[S-1][1];
    assign last_v = stg_v[S-1];
  end else begin : g_nostg
    // two operands need no CSA layer: feed the adder directly
    always_comb begin
      stg_v = '0;
      for (int s = 0; s < SD; s++)
        for (int j = 0; j < NUM_PP; j++)
          stg_q[s][j] = '0;
    end

    assign cpa_a  = ext[0];
    assign cpa_b  = ext[1];
    assign last_v = in_valid;
  end

  // registered carry-propagate add; holds result while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (!stall) begin
      out_valid <= last_v;
      out_sum   <= cpa_a + cpa_b;
    end
  end

endmodule

// File: tb/tb_wta_pipe_tree.sv
// Directed bench for wta_pipe_tree at defaults, plus random
// sweeps of the NUM_PP=3 and NUM_PP=2 configurations.
module tb_wta_pipe_tree;

  localparam int N   = 10;
  localparam int W   = 32;
  localparam int OW  = 36;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  pp_in;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_sum;

  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [23:0]     a_pp;
  logic [9:0]      a_out_sum;
  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]     b_pp;
  logic [8:0]      b_out_sum;

  int checks = 0;
  int failures = 0;

  wta_pipe_tree dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .pp_in(pp_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  wta_pipe_tree #(.NUM_PP(3), .PP_WIDTH(8), .REG_EVERY(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .pp_in(a_pp),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum)
  );

  wta_pipe_tree #(.NUM_PP(2), .PP_WIDTH(8), .REG_EVERY(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .pp_in(b_pp),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] gold(input logic [N*W-1:0] v);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < N; i++)
      s += {32'h0, v[i*W +: W]};
    return s;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = $urandom();
    return v;
  endfunction

  logic [N*W-1:0] vecs [8];
  logic [63:0]    qa [$];
  logic [63:0]    qb [$];
  logic [63:0]    held;
  logic [63:0]    e;
  int             idx, rcv, sent, cyc;
  logic           pstall;

  initial begin
    in_valid = 0; out_ready = 1; pp_in = '0;
    a_in_valid = 0; a_out_ready = 1; a_pp = '0;
    b_in_valid = 0; b_out_ready = 1; b_pp = '0;

    #12;
    chk("reset_valid", out_valid, 0);
    chk("reset_sum", out_sum, 0);
    rst_n = 1;
    tick();
    chk("ready_after_reset", in_ready, 1);

    // all ones: sum 10*0xFFFFFFFF, latency LAT
    pp_in = '1;
    in_valid = 1;
    tick();
    in_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      chk("t1_valid", out_valid, (c == LAT) ? 1 : 0);
      if (c == LAT) chk("t1_sum", out_sum, 64'h9FFFFFFF6);
      tick();
    end

    // pp_i = i+1, then all zero
    for (int i = 0; i < N; i++)
      pp_in[i*W +: W] = i + 1;
    in_valid = 1;
    tick();
    pp_in = '0;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("t2_valid_a", out_valid, 1);
    chk("t2_sum_a", out_sum, 64'h37);
    tick();
    chk("t2_valid_b", out_valid, 1);
    chk("t2_sum_b", out_sum, 64'h0);
    tick();
    chk("t2_valid_c", out_valid, 0);

    // eight back-to-back random vectors
    for (int i = 0; i < 8; i++)
      vecs[i] = rand_vec();
    for (int i = 0; i <= LAT + 8; i++) begin
      in_valid = (i < 8);
      pp_in = (i < 8) ? vecs[i] : '0;
      if (i >= LAT && i < LAT + 8) begin
        chk("t3_valid", out_valid, 1);
        chk("t3_sum", out_sum, gold(vecs[i-LAT]));
      end else begin
        chk("t3_bubble", out_valid, 0);
      end
      tick();
    end
    in_valid = 0;

    // six vectors, out_ready low for cycles 5..7
    for (int i = 0; i < 8; i++)
      vecs[i] = rand_vec();
    idx = 0;
    rcv = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 6);
      pp_in = (idx < 6) ? vecs[idx] : '0;
      out_ready = !(c >= 5 && c <= 7);
      #1;
      if (!out_ready) begin
        chk("t4_stall_valid", out_valid, 1);
        chk("t4_stall_ready", in_ready, 0);
        if (c == 5) held = out_sum;
        else chk("t4_hold", out_sum, held);
      end
      if (out_valid && out_ready) begin
        if (rcv < 6) chk("t4_sum", out_sum, gold(vecs[rcv]));
        else chk("t4_extra", 1, 0);
        rcv++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    chk("t4_count", rcv, 6);
    in_valid = 0;
    out_ready = 1;

    // reset with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      pp_in = vecs[i];
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    tick();
    chk("t5_pre_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    tick();
    #2 rst_n = 1;
    tick();
    chk("t5_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_stale", out_valid, 0);
      tick();
    end
    pp_in = vecs[7];
    in_valid = 1;
    tick();
    in_valid = 0;
    for (int c = 1; c <= 5; c++) begin
      chk("t5_valid", out_valid, (c == LAT) ? 1 : 0);
      if (c == LAT) chk("t5_sum", out_sum, gold(vecs[7]));
      tick();
    end

    // NUM_PP=3, PP_WIDTH=8: random valid and ready
    sent = 0; rcv = 0; cyc = 0; pstall = 0; held = '0;
    while ((sent < 1000 || qa.size() > 0) && cyc < 20000) begin
      a_in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a_pp = $urandom();
      a_out_ready = ($urandom_range(0, 3) != 0) || (sent >= 1000);
      #1;
      if (pstall) chk("a_hold", a_out_sum, held);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() > 0) chk("a_sum", a_out_sum, qa.pop_front());
        else chk("a_extra", 1, 0);
        rcv++;
      end
      if (a_in_valid && a_in_ready) begin
        e = a_pp[7:0] + a_pp[15:8] + a_pp[23:16];
        qa.push_back(e);
        sent++;
      end
      pstall = a_out_valid && !a_out_ready;
      held = a_out_sum;
      tick();
      cyc++;
    end
    a_in_valid = 0;
    chk("a_count", rcv, 1000);

    // NUM_PP=2: no CSA layers
    sent = 0; rcv = 0; cyc = 0; pstall = 0; held = '0;
    while ((sent < 1000 || qb.size() > 0) && cyc < 20000) begin
      b_in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b_pp = $urandom();
      b_out_ready = ($urandom_range(0, 3) != 0) || (sent >= 1000);
      #1;
      if (pstall) chk("b_hold", b_out_sum, held);
      if (b_out_valid && b_out_ready) begin
        if (qb.size() > 0) chk("b_sum", b_out_sum, qb.pop_front());
        else chk("b_extra", 1, 0);
        rcv++;
      end
      if (b_in_valid && b_in_ready) begin
        e = b_pp[7:0] + b_pp[15:8];
        qb.push_back(e);
        sent++;
      end
      pstall = b_out_valid && !b_out_ready;
      held = b_out_sum;
      tick();
      cyc++;
    end
    b_in_valid = 0;
    chk("b_count", rcv, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
